// File: rtl/e_xlu_pkg.sv
// rtl/e_xlu_pkg.sv - shared XLU op codes, latency defaults and state type
package e_xlu_pkg;

    localparam logic [3:0] XLU_MULT  = 4'b0000;
    localparam logic [3:0] XLU_MULTU = 4'b0001;
    localparam logic [3:0] XLU_DIV   = 4'b0010;
    localparam logic [3:0] XLU_DIVU  = 4'b0011;
    localparam logic [3:0] XLU_MTHI  = 4'b0100;
    localparam logic [3:0] XLU_MTLO  = 4'b0101;
    localparam logic [3:0] XLU_MFHI  = 4'b0110;
    localparam logic [3:0] XLU_MFLO  = 4'b0111;
    localparam logic [3:0] XLU_NONE  = 4'b1000;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    typedef enum logic {
        XLU_IDLE = 1'b0,
        XLU_BUSY = 1'b1
    } xlu_state_e;

    function automatic logic is_muldiv(input logic [3:0] op);
        return (op[3:2] == 2'b00);
    endfunction

endpackage

// File: rtl/e_xlu_div.sv
// rtl/e_xlu_div.sv - combinational signed/unsigned 32-bit divide with zero-divisor flag
module e_xlu_div (
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    input  logic        is_signed,
    output logic [31:0] quot,
    output logic [31:0] rem,
    output logic        div_zero
);

    logic        neg_a;
    logic        neg_b;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] safe_b;
    logic [31:0] uq;
    logic [31:0] ur;

    // Divide magnitudes then restore signs: this keeps 0x80000000 / -1 well defined
    // (quotient wraps back to 0x80000000) and never presents a zero divisor.
    always_comb begin
        neg_a    = is_signed & dividend[31];
        neg_b    = is_signed & divisor[31];
        mag_a    = neg_a ? (32'd0 - dividend) : dividend;
        mag_b    = neg_b ? (32'd0 - divisor) : divisor;
        div_zero = (divisor == 32'd0);
        safe_b   = div_zero ? 32'd1 : mag_b;
        uq       = mag_a / safe_b;
        ur       = mag_a % safe_b;
        quot     = (neg_a ^ neg_b) ? (32'd0 - uq) : uq;
        rem      = neg_a ? (32'd0 - ur) : ur;
    end

endmodule

// File: rtl/e_xlu.sv
// rtl/e_xlu.sv - E-stage multiply/divide unit holding HI/LO with fixed-latency busy window
module e_xlu
    import e_xlu_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [3:0]  xlu_op,
    input  logic        mfhi_op,
    input  logic        mflo_op,
    input  logic        flush,
    output logic        start,
    output logic        busy,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out,
    output logic [31:0] xlu_out
);

    localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    xlu_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;
    logic [31:0]      phi_q, phi_d;
    logic [31:0]      plo_q, plo_d;

    logic        signed_mul;
    logic [63:0] ext_a;
    logic [63:0] ext_b;
    logic [63:0] prod;
    logic [31:0] div_q;
    logic [31:0] div_r;
    logic        div_zero;

    // Sign-extending to 64 bits lets one unsigned multiplier serve both mult and multu.
    always_comb begin
        signed_mul = (xlu_op == XLU_MULT);
        ext_a      = signed_mul ? {{32{A[31]}}, A} : {32'd0, A};
        ext_b      = signed_mul ? {{32{B[31]}}, B} : {32'd0, B};
        prod       = ext_a * ext_b;
    end

    e_xlu_div u_div (
        .dividend  (A),
        .divisor   (B),
        .is_signed (xlu_op == XLU_DIV),
        .quot      (div_q),
        .rem       (div_r),
        .div_zero  (div_zero)
    );

    assign busy  = (state_q == XLU_BUSY);
    assign start = is_muldiv(xlu_op) & ~busy & ~flush;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        phi_d   = phi_q;
        plo_d   = plo_q;
        case (state_q)
            XLU_IDLE: begin
                if (start) begin
                    state_d = XLU_BUSY;
                    if (xlu_op[1]) begin
                        cnt_d = CNT_W'(DIV_CYCLES);
                        // A zero divisor recommits the current HI/LO, leaving them unchanged.
                        phi_d = div_zero ? hi_q : div_r;
                        plo_d = div_zero ? lo_q : div_q;
                    end else begin
                        cnt_d = CNT_W'(MULT_CYCLES);
                        phi_d = prod[63:32];
                        plo_d = prod[31:0];
                    end
                end else if (!flush) begin
                    if (xlu_op == XLU_MTHI) hi_d = A;
                    if (xlu_op == XLU_MTLO) lo_d = A;
                end
            end
            XLU_BUSY: begin
                if (cnt_q == CNT_W'(1)) begin
                    state_d = XLU_IDLE;
                    cnt_d   = '0;
                    hi_d    = phi_q;
                    lo_d    = plo_q;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = XLU_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= XLU_IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            phi_q   <= '0;
            plo_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            phi_q   <= phi_d;
            plo_q   <= plo_d;
        end
    end

    assign hi_out  = hi_q;
    assign lo_out  = lo_q;
    assign xlu_out = mfhi_op ? hi_q : (mflo_op ? lo_q : 32'd0);

endmodule

// File: tb/tb_e_xlu.sv
// tb/tb_e_xlu.sv - directed self-checking bench for e_xlu
module tb_e_xlu;
    import e_xlu_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] A;
    logic [31:0] B;
    logic [3:0]  xlu_op;
    logic        mfhi_op;
    logic        mflo_op;
    logic        flush;
    logic        start;
    logic        busy;
    logic [31:0] hi_out;
    logic [31:0] lo_out;
    logic [31:0] xlu_out;

    int vectors = 0;
    int errs    = 0;
    int n;

    e_xlu dut (
        .clk     (clk),
        .reset   (reset),
        .A       (A),
        .B       (B),
        .xlu_op  (xlu_op),
        .mfhi_op (mfhi_op),
        .mflo_op (mflo_op),
        .flush   (flush),
        .start   (start),
        .busy    (busy),
        .hi_out  (hi_out),
        .lo_out  (lo_out),
        .xlu_out (xlu_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive an op, confirm start combinationally, clock it in, then return to NONE.
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic exp_start, input string tag);
        xlu_op = op;
        A      = a;
        B      = b;
        #1;
        chk({tag, "_start"}, {31'd0, start}, {31'd0, exp_start});
        step();
        xlu_op = XLU_NONE;
    endtask

    task automatic wait_idle(output int cnt);
        cnt = 0;
        while (busy && cnt < 40) begin
            cnt++;
            step();
        end
    endtask

    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int cycles, input logic [31:0] ehi, input logic [31:0] elo,
                          input string tag);
        int c;
        issue(op, a, b, 1'b1, tag);
        wait_idle(c);
        chk({tag, "_cycles"}, c, cycles);
        chk({tag, "_hi"}, hi_out, ehi);
        chk({tag, "_lo"}, lo_out, elo);
    endtask

    initial begin
        reset   = 1'b1;
        A       = 32'd0;
        B       = 32'd0;
        xlu_op  = XLU_MULT;
        mfhi_op = 1'b0;
        mflo_op = 1'b0;
        flush   = 1'b0;
        #1;
        chk("rst_start", {31'd0, start}, 32'd1);
        step();
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_hi", hi_out, 32'd0);
        chk("rst_lo", lo_out, 32'd0);
        xlu_op = XLU_NONE;
        reset  = 1'b0;
        step();

        run_op(XLU_MULT, 32'hFFFFFFFE, 32'd3, 5, 32'hFFFFFFFF, 32'hFFFFFFFA, "mult");
        mfhi_op = 1'b1;
        #1 chk("mfhi", xlu_out, 32'hFFFFFFFF);
        mflo_op = 1'b1;
        #1 chk("mfhi_prio", xlu_out, 32'hFFFFFFFF);
        mfhi_op = 1'b0;
        #1 chk("mflo", xlu_out, 32'hFFFFFFFA);
        mflo_op = 1'b0;
        #1 chk("mf_none", xlu_out, 32'd0);

        run_op(XLU_MULTU, 32'hFFFFFFFE, 32'd3, 5, 32'h00000002, 32'hFFFFFFFA, "multu");
        run_op(XLU_DIV, 32'hFFFFFFF9, 32'd2, 10, 32'hFFFFFFFF, 32'hFFFFFFFD, "div_neg");
        run_op(XLU_DIV, 32'd7, 32'hFFFFFFFE, 10, 32'h00000001, 32'hFFFFFFFD, "div_negb");
        run_op(XLU_DIV, 32'h80000000, 32'hFFFFFFFF, 10, 32'h00000000, 32'h80000000, "div_ovf");
        run_op(XLU_DIVU, 32'd100, 32'd7, 10, 32'h00000002, 32'h0000000E, "divu");

        issue(XLU_MTHI, 32'h11, 32'd0, 1'b0, "mthi");
        issue(XLU_MTLO, 32'h22, 32'd0, 1'b0, "mtlo");
        chk("mthi_hi", hi_out, 32'h11);
        chk("mtlo_lo", lo_out, 32'h22);
        run_op(XLU_DIVU, 32'd100, 32'd0, 10, 32'h11, 32'h22, "divu_zero");

        flush = 1'b1;
        issue(XLU_MULT, 32'd9, 32'd9, 1'b0, "flush_mult");
        chk("flush_busy", {31'd0, busy}, 32'd0);
        issue(XLU_MTHI, 32'h5, 32'd0, 1'b0, "flush_mthi");
        flush = 1'b0;
        chk("flush_hi", hi_out, 32'h11);
        chk("flush_lo", lo_out, 32'h22);

        // In-flight mult survives flush and ignores ops issued while busy.
        issue(XLU_MULT, 32'h10000, 32'h10000, 1'b1, "inflight");
        flush = 1'b1;
        step();
        flush = 1'b0;
        xlu_op = XLU_MTHI;
        A      = 32'hDEAD;
        #1 chk("busy_mthi_start", {31'd0, start}, 32'd0);
        step();
        xlu_op = XLU_MULT;
        A      = 32'd5;
        B      = 32'd5;
        #1 chk("busy_mult_start", {31'd0, start}, 32'd0);
        step();
        xlu_op  = XLU_NONE;
        mflo_op = 1'b1;
        #1 chk("busy_mflo", xlu_out, 32'h22);
        chk("busy_hi_old", hi_out, 32'h11);
        mflo_op = 1'b0;
        wait_idle(n);
        chk("inflight_cycles", n + 3, 32'd5);
        chk("inflight_hi", hi_out, 32'h1);
        chk("inflight_lo", lo_out, 32'h0);

        issue(XLU_DIV, 32'hFFFFFFF9, 32'd2, 1'b1, "rst_div");
        step();
        step();
        chk("rst_div_busy3", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        #1;
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_hi", hi_out, 32'd0);
        chk("midrst_lo", lo_out, 32'd0);
        step();
        reset = 1'b0;
        step();
        chk("post_rst_busy", {31'd0, busy}, 32'd0);
        chk("post_rst_lo", lo_out, 32'd0);
        run_op(XLU_MULT, 32'd3, 32'd4, 5, 32'd0, 32'h0000000C, "post_rst_mult");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
